// File: rtl/freq_meter_pkg.sv
// Shared constants for the frequency/period meter and its synchronizer.
package freq_meter_pkg;

    localparam int unsigned GATE_CYCLES_DEF = 1000;
    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned PER_W_DEF       = 16;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] GATE = 1'b1;

endpackage

// File: rtl/edge_sync.sv
// Three-flop synchronizer for an asynchronous level, with a one-cycle pulse
// per sampled rising transition.
module edge_sync (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic rise_pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= async_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // r_s1 may be metastable; only r_s2/r_s3 feed logic.
    assign rise_pulse = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_meter.sv
// Edge count per fixed gate window and CLK-cycle period between rising edges
// of a slow external signal.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned PER_W       = PER_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             overflow,
    output logic [PER_W-1:0] period,
    output logic             period_valid
);

    localparam int unsigned      GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [PER_W-1:0] PER_MAX   = '1;

    logic w_edge;

    edge_sync u_edge_sync (
        .CLK        (CLK),
        .RST        (RST),
        .async_in   (sig_in),
        .rise_pulse (w_edge)
    );

    logic [0:0]       r_state;
    logic [GW-1:0]    r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [CNT_W:0]   w_edge_sum;
    logic [CNT_W-1:0] w_edge_sat;
    logic             w_sat_hit;

    // One extra bit so the carry out of the saturating add is visible.
    always_comb begin
        w_edge_sum = {1'b0, r_edge_cnt} + (CNT_W + 1)'(w_edge);
        w_sat_hit  = (w_edge_sum >= {1'b0, CNT_MAX});
        w_edge_sat = w_sat_hit ? CNT_MAX : w_edge_sum[CNT_W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            freq_count <= '0;
            overflow   <= 1'b0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    if (en) begin
                        r_state <= GATE;
                    end
                end
                GATE: begin
                    if (!en) begin
                        r_state    <= IDLE;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                    end else if (r_gate_cnt == GATE_LAST) begin
                        // Last-cycle edge is folded in here, never into the next window.
                        freq_count <= w_edge_sat;
                        overflow   <= w_sat_hit;
                        freq_valid <= 1'b1;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + 1'b1;
                        r_edge_cnt <= w_edge_sat;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    logic [PER_W-1:0] r_per_cnt;
    logic             r_armed;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_per_cnt    <= '0;
            r_armed      <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!en) begin
                r_per_cnt <= '0;
                r_armed   <= 1'b0;
            end else if (w_edge) begin
                // Restart at 1 so the next edge reads the true cycle distance.
                r_per_cnt <= PER_W'(1);
                r_armed   <= 1'b1;
                if (r_armed) begin
                    period       <= r_per_cnt;
                    period_valid <= 1'b1;
                end
            end else if (r_per_cnt != PER_MAX) begin
                r_per_cnt <= r_per_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed + randomized bench for freq_meter, two parameterizations driven in
// parallel and checked every cycle against an edge-time reference model.
module tb_freq_meter;

    localparam int unsigned G    = 100;
    localparam int unsigned CW_A = 16;
    localparam int unsigned PW_A = 16;
    localparam int unsigned CW_B = 4;
    localparam int unsigned PW_B = 6;

    logic CLK = 1'b0;
    logic RST;
    logic en;
    logic sig_in;

    logic [CW_A-1:0] fc_a;
    logic            fv_a;
    logic            ov_a;
    logic [PW_A-1:0] per_a;
    logic            pv_a;
    logic [CW_B-1:0] fc_b;
    logic            fv_b;
    logic            ov_b;
    logic [PW_B-1:0] per_b;
    logic            pv_b;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(CW_A), .PER_W(PW_A)) dut_a (
        .CLK(CLK), .RST(RST), .en(en), .sig_in(sig_in),
        .freq_count(fc_a), .freq_valid(fv_a), .overflow(ov_a),
        .period(per_a), .period_valid(pv_a)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(CW_B), .PER_W(PW_B)) dut_b (
        .CLK(CLK), .RST(RST), .en(en), .sig_in(sig_in),
        .freq_count(fc_b), .freq_valid(fv_b), .overflow(ov_b),
        .period(per_b), .period_valid(pv_b)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: sig_in level sampled at each clock edge, and the
    // resulting edge instants, window boundaries and last edge time.
    bit samp [0:16383];
    int n = -1;
    bit win_on = 1'b0;
    int win_start = 0;
    int win_edges = 0;
    bit armed = 1'b0;
    int last_edge = 0;
    longint cmax [2] = '{65535, 15};
    longint pmax [2] = '{65535, 63};
    longint m_fc [2] = '{0, 0};
    longint m_ov [2] = '{0, 0};
    longint m_per [2] = '{0, 0};
    bit m_fv = 1'b0;
    bit m_pv = 1'b0;
    int ph = 0;

    function automatic bit samp_at(input int k);
        return (k < 0) ? 1'b0 : samp[k];
    endfunction

    function automatic longint min2(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit s, input bit e, input bit r);
        bit ed;
        ed = samp_at(n - 2) & ~samp_at(n - 3);
        samp[n] = s;
        m_fv = 1'b0;
        m_pv = 1'b0;
        if (r) begin
            samp[n] = 1'b0;
            if (n >= 1) samp[n-1] = 1'b0;
            if (n >= 2) samp[n-2] = 1'b0;
            win_on = 1'b0;
            armed  = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_fc[i] = 0; m_ov[i] = 0; m_per[i] = 0;
            end
        end else begin
            if (!e) begin
                win_on = 1'b0;
            end else if (!win_on) begin
                win_on = 1'b1;
                win_start = n + 1;
                win_edges = 0;
            end else begin
                win_edges += int'(ed);
                if (n == win_start + int'(G) - 1) begin
                    for (int i = 0; i < 2; i++) begin
                        m_fc[i] = min2(win_edges, cmax[i]);
                        m_ov[i] = (win_edges >= cmax[i]) ? 1 : 0;
                    end
                    m_fv = 1'b1;
                    win_start = n + 1;
                    win_edges = 0;
                end
            end
            if (!e) begin
                armed = 1'b0;
            end else if (ed) begin
                if (armed) begin
                    for (int i = 0; i < 2; i++) m_per[i] = min2(n - last_edge, pmax[i]);
                    m_pv = 1'b1;
                end
                armed = 1'b1;
                last_edge = n;
            end
        end
    endtask

    task automatic tick(input bit s, input bit e, input bit r);
        sig_in = s;
        en     = e;
        RST    = r;
        @(posedge CLK);
        n++;
        model(s, e, r);
        #1;
        check("fc_a",  64'(fc_a),  64'(m_fc[0]));
        check("ov_a",  64'(ov_a),  64'(m_ov[0]));
        check("fv_a",  64'(fv_a),  64'(m_fv));
        check("per_a", 64'(per_a), 64'(m_per[0]));
        check("pv_a",  64'(pv_a),  64'(m_pv));
        check("fc_b",  64'(fc_b),  64'(m_fc[1]));
        check("ov_b",  64'(ov_b),  64'(m_ov[1]));
        check("fv_b",  64'(fv_b),  64'(m_fv));
        check("per_b", 64'(per_b), 64'(m_per[1]));
        check("pv_b",  64'(pv_b),  64'(m_pv));
    endtask

    task automatic sq10(input bit e, input bit r);
        tick((ph % 10) < 5, e, r);
        ph++;
    endtask

    initial begin
        int cnt;
        bit found;
        int close;
        int hold;
        bit lvl;
        int off_left;

        // Reset state
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1);
        check("reset fc_a", 64'(fc_a), 64'd0);
        check("reset per_a", 64'(per_a), 64'd0);

        // CLK/10 square
        for (int i = 0; i < 350; i++) sq10(1'b1, 1'b0);
        check("sq10 fc_a", 64'(fc_a), 64'd10);
        check("sq10 ov_a", 64'(ov_a), 64'd0);
        check("sq10 per_a", 64'(per_a), 64'd10);
        check("sq10 per_b", 64'(per_b), 64'd10);

        // CLK/2 toggle
        for (int i = 0; i < 300; i++) tick(i[0], 1'b1, 1'b0);
        check("tog fc_a", 64'(fc_a), 64'd50);
        check("tog per_a", 64'(per_a), 64'd2);
        check("tog fc_b sat", 64'(fc_b), 64'd15);
        check("tog ov_b", 64'(ov_b), 64'd1);
        check("tog ov_a", 64'(ov_a), 64'd0);

        // Held low, then held high
        for (int i = 0; i < 220; i++) tick(1'b0, 1'b1, 1'b0);
        check("held0 fc_a", 64'(fc_a), 64'd0);
        for (int i = 0; i < 220; i++) tick(1'b1, 1'b1, 1'b0);
        check("held1 fc_a", 64'(fc_a), 64'd0);

        // Slow square, period saturates in the narrow instance
        for (int i = 0; i < 320; i++) tick((i % 80) < 40, 1'b1, 1'b0);
        check("slow per_a", 64'(per_a), 64'd80);
        check("slow per_b sat", 64'(per_b), 64'd63);

        // Abort at gate_cnt=50, re-enable 20 cycles later
        cnt = 0;
        while (((n + 1) != win_start + 50 || !win_on) && cnt < 3 * G) begin
            sq10(1'b1, 1'b0);
            cnt++;
        end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sq10(1'b0, 1'b0);
            if (fv_a === 1'b1) found = 1'b1;
        end
        check("abort no fv", 64'(found), 64'd0);
        sq10(1'b1, 1'b0);
        cnt = 0;
        found = 1'b0;
        while (!found && cnt < 3 * G) begin
            sq10(1'b1, 1'b0);
            cnt++;
            if (fv_a === 1'b1) found = 1'b1;
        end
        check("reenable latency", found ? 64'(cnt) : 64'd0, 64'(G));

        // One-cycle reset mid-window
        for (int i = 0; i < 37; i++) sq10(1'b1, 1'b0);
        sq10(1'b1, 1'b1);
        check("rst fc_a", 64'(fc_a), 64'd0);
        check("rst fv_a", 64'(fv_a), 64'd0);
        check("rst per_a", 64'(per_a), 64'd0);
        sq10(1'b1, 1'b0);
        cnt = 0;
        found = 1'b0;
        while (!found && cnt < 3 * G) begin
            sq10(1'b1, 1'b0);
            cnt++;
            if (fv_a === 1'b1) found = 1'b1;
        end
        check("post-rst latency", found ? 64'(cnt) : 64'd0, 64'(G));

        // Single edge landing in the last cycle of a window
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0);
        cnt = 0;
        while ((n + 1) != win_start && cnt < 3 * G) begin
            tick(1'b0, 1'b1, 1'b0);
            cnt++;
        end
        close = win_start + int'(G) - 1;
        while ((n + 1) < close - 2) tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0);
        check("last-cycle edge counted", 64'(fc_a), 64'd1);
        for (int i = 0; i < int'(G); i++) tick(1'b0, 1'b1, 1'b0);
        check("next window empty", 64'(fc_a), 64'd0);

        // Random levels, enable drops and occasional reset
        hold = 0;
        lvl = 1'b0;
        off_left = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                lvl  = ~lvl;
                hold = $urandom_range(1, 12);
            end
            hold--;
            if (off_left == 0 && $urandom_range(0, 149) == 0) off_left = $urandom_range(5, 30);
            tick(lvl, off_left == 0, $urandom_range(0, 499) == 0);
            if (off_left > 0) off_left--;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures a slow square-wave input, such as a divided board clock or any external toggling signal. It is the receiving end of the clock-divider path: dividers turn a cycle count into a frequency, and this block turns a frequency back into counts.
- Produces two results on the CLK time base:
  - edges per fixed gate window (frequency);
  - CLK cycles between consecutive rising edges (period).
- Sits beside the divider blocks on the board top level. Used for self-check and for display on the seven-segment/LED outputs.

Parameters:
GATE_CYCLES, 1000, length of one frequency gate window in CLK cycles (must be >= 2)
CNT_W, 16, width of the edge counter / freq_count
PER_W, 16, width of the period counter / period

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
en  input  1  measurement enable; low = idle, counters held cleared
sig_in  input  1  signal under measurement, asynchronous to CLK
freq_count  output  CNT_W  rising edges counted in last completed window
freq_valid  output  1  one-cycle pulse when freq_count updates
overflow  output  1  edge counter saturated in last completed window
period  output  PER_W  CLK cycles between last two rising edges
period_valid  output  1  one-cycle pulse when period updates

Behaviour:
- Clocking and reset:
  - One clock (CLK); reset is synchronous and active-high (RST).
  - On RST, all outputs go to 0, state is IDLE, and all counters and synchronizer flops are cleared. RST overrides en in the same cycle.
- Input synchronizer:
  - 3-flop chain s1 -> s2 -> s3; edge = s2 & ~s3.
  - A sig_in rise sampled at CLK edge k produces edge high during the cycle after edge k+1, i.e. 2-cycle latency.
  - Exactly one edge pulse per sampled rise. Falling edges are ignored.
- Frequency FSM:
  - IDLE: gate_cnt=0, edge_cnt=0. Go to GATE when en=1.
  - GATE: gate_cnt counts 0..GATE_CYCLES-1. edge_cnt increments on edge and saturates at 2^CNT_W-1.
  - In the cycle gate_cnt==GATE_CYCLES-1:
    - freq_count <= edge_cnt + edge, saturated;
    - overflow <= (saturation reached in this window);
    - freq_valid <= 1 for exactly the next cycle.
    - gate_cnt and edge_cnt restart at 0, so windows run back-to-back with no dead cycle. An edge in the last cycle counts in the closing window, never the next.
  - GATE -> IDLE when en=0: the window is aborted, with no freq_valid, and freq_count/overflow keep their previous values.
- Period path:
  - Active only when en=1. When en=0: per_cnt=0 and armed=0.
  - per_cnt increments every cycle and saturates at 2^PER_W-1.
  - On an edge with armed=0: armed <= 1, per_cnt <= 1, no output.
  - On an edge with armed=1: period <= per_cnt, period_valid <= 1 for one cycle, per_cnt <= 1.
    - Result: edges in cycles t0 and t1 give period = t1 - t0.
    - A saturated value is reported as all-ones.
  - The first edge after en rises only arms the path.
- Outputs:
  - freq_count, overflow and period are registered and hold between updates.
  - freq_valid and period_valid may assert in the same cycle; they are independent.
- Reset mid-window: the partial result is discarded and the next window starts from gate_cnt=0 once RST=0 and en=1.

Decomposition:
- Package freq_meter_pkg holds:
  - default constants: GATE_CYCLES_DEF=1000, CNT_W_DEF=16, PER_W_DEF=16;
  - FSM state encoding: IDLE=1'b0, GATE=1'b1.
- One sub-module, edge_sync:
  - ports CLK, RST, async_in, rise_pulse;
  - the 3-flop synchronizer plus rising-edge detect;
  - reused by future button and debounce blocks.

Test Plan:
1. GATE_CYCLES=100, sig_in = CLK/10 square (5 high/5 low), en=1 -> after each window freq_count=10 with freq_valid a single pulse every 100 cycles, overflow=0; period=10 on every period_valid after the first (arming) edge.
2. sig_in = CLK/2 toggling each cycle, GATE_CYCLES=100 -> freq_count=50, period=2; with CNT_W=4 -> freq_count=15, overflow=1.
3. sig_in held at 0, then held at 1 -> freq_count=0 each window, period_valid never asserts.
4. en dropped at gate_cnt=50, then raised 20 cycles later -> no freq_valid for the aborted window; the next freq_valid comes 100 cycles after en re-rises; the first edge after re-enable produces no period_valid.
5. RST pulsed for 1 cycle mid-window with en=1 -> all outputs 0 the following cycle; the first post-reset freq_valid comes GATE_CYCLES cycles after RST falls, with a correct count.
6. Single sig_in pulse rising exactly 2 cycles before window end, so edge lands in the last cycle -> counted in the closing window (freq_count=1), next window 0.
